// File: rtl/seg_display_capture_if.sv
// Multiplexed 7-segment display bus as seen by the capture block, plus its decoded results.
interface seg_display_capture_if;
    logic [6:0]  mostrador;
    logic [3:0]  digits;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        value_valid;
    logic        pattern_err;
    logic        scan_lost;

    modport master (
        output mostrador, digits,
        input  value, blank, value_valid, pattern_err, scan_lost
    );

    modport slave (
        input  mostrador, digits,
        output value, blank, value_valid, pattern_err, scan_lost
    );
endinterface

// File: rtl/seg_display_capture.sv
// Samples a scanned 4-digit 7-segment display, decodes it back to BCD and publishes
// a frame once it has been seen identically for STABLE_FRAMES complete scans.
module seg_display_capture #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned STABLE_FRAMES  = 3,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input logic                  clk_50mhz,
    input logic                  init_pulse,
    seg_display_capture_if.slave bus
);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {WAIT_SEL, SETTLE, SAMPLE, HOLD} state_t;

    state_t          state_q, state_d;
    logic [6:0]      mostrador_s1_q, mostrador_s2_q;
    logic [3:0]      digits_s1_q, digits_s2_q;
    logic [3:0]      sel_act_q, sel_act_d;
    logic [SW-1:0]   settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [MW-1:0]   match_q, match_d;
    logic [3:0][3:0] frame_nib_q, frame_nib_d;
    logic [3:0]      frame_blank_q, frame_blank_d;
    logic [3:0]      frame_inv_q, frame_inv_d;
    logic [3:0]      seen_q, seen_d;
    logic [3:0][3:0] prev_nib_q, prev_nib_d;
    logic [3:0]      prev_blank_q, prev_blank_d;
    logic [15:0]     value_q, value_d;
    logic [3:0]      blank_q, blank_d;
    logic            value_valid_q, value_valid_d;
    logic            pattern_err_q, pattern_err_d;

    logic [6:0] seg;
    logic [3:0] sel;
    logic [3:0] dec_nib;
    logic       dec_blank, dec_inv;
    logic [1:0] slot;

    always_comb begin
        seg = SEG_ACTIVE_LOW ? ~mostrador_s2_q : mostrador_s2_q;
        sel = DIG_ACTIVE_LOW ? ~digits_s2_q : digits_s2_q;
    end

    always_comb begin
        dec_nib   = 4'hF;
        dec_blank = 1'b0;
        dec_inv   = 1'b0;
        case (seg)
            7'b1111110: dec_nib = 4'd0;
            7'b0110000: dec_nib = 4'd1;
            7'b1101101: dec_nib = 4'd2;
            7'b1111001: dec_nib = 4'd3;
            7'b0110011: dec_nib = 4'd4;
            7'b1011011: dec_nib = 4'd5;
            7'b1011111: dec_nib = 4'd6;
            7'b1110000: dec_nib = 4'd7;
            7'b1111111: dec_nib = 4'd8;
            7'b1111011: dec_nib = 4'd9;
            7'b0000000: dec_blank = 1'b1;
            default:    dec_inv = 1'b1;
        endcase
    end

    always_comb begin
        case (sel_act_q)
            4'b1000: slot = 2'd3;
            4'b0100: slot = 2'd2;
            4'b0010: slot = 2'd1;
            default: slot = 2'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        sel_act_d     = sel_act_q;
        settle_cnt_d  = settle_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        match_d       = match_q;
        frame_nib_d   = frame_nib_q;
        frame_blank_d = frame_blank_q;
        frame_inv_d   = frame_inv_q;
        seen_d        = seen_q;
        prev_nib_d    = prev_nib_q;
        prev_blank_d  = prev_blank_q;
        value_d       = value_q;
        blank_d       = blank_q;
        value_valid_d = 1'b0;
        pattern_err_d = pattern_err_q;

        // Frame completion is evaluated one cycle after the SAMPLE that filled the last slot.
        if (seen_q == 4'hF) begin
            seen_d = '0;
            if (|frame_inv_q) begin
                pattern_err_d = 1'b1;
                match_d       = '0;
            end else begin
                pattern_err_d = 1'b0;
                if (frame_nib_q == prev_nib_q && frame_blank_q == prev_blank_q)
                    match_d = (match_q == MW'(STABLE_FRAMES)) ? match_q : match_q + MW'(1);
                else
                    match_d = MW'(1);
                prev_nib_d   = frame_nib_q;
                prev_blank_d = frame_blank_q;
                if (match_d == MW'(STABLE_FRAMES) &&
                    (frame_nib_q != value_q || frame_blank_q != blank_q)) begin
                    value_d       = frame_nib_q;
                    blank_d       = frame_blank_q;
                    value_valid_d = 1'b1;
                end
            end
        end

        case (state_q)
            WAIT_SEL: begin
                if ($onehot(sel)) begin
                    sel_act_d    = sel;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (sel != sel_act_q)
                    state_d = WAIT_SEL;
                else if (settle_cnt_q == SW'(SETTLE_CYCLES - 1))
                    state_d = SAMPLE;
                else
                    settle_cnt_d = settle_cnt_q + SW'(1);
            end
            SAMPLE: begin
                frame_nib_d[slot]   = dec_nib;
                frame_blank_d[slot] = dec_blank;
                frame_inv_d[slot]   = dec_inv;
                seen_d[slot]        = 1'b1;
                state_d             = HOLD;
            end
            HOLD: begin
                if (sel != sel_act_q)
                    state_d = WAIT_SEL;
            end
            default: state_d = WAIT_SEL;
        endcase

        if (state_q == SAMPLE)
            tmo_cnt_d = '0;
        else if (tmo_cnt_q != TW'(TIMEOUT_CYCLES))
            tmo_cnt_d = tmo_cnt_q + TW'(1);

        // Losing the scan forgets stability history so a stale frame cannot republish.
        if (tmo_cnt_d == TW'(TIMEOUT_CYCLES) && tmo_cnt_q != TW'(TIMEOUT_CYCLES))
            match_d = '0;
    end

    always_ff @(posedge clk_50mhz) begin
        if (init_pulse) begin
            state_q        <= WAIT_SEL;
            mostrador_s1_q <= '0;
            mostrador_s2_q <= '0;
            digits_s1_q    <= '0;
            digits_s2_q    <= '0;
            sel_act_q      <= '0;
            settle_cnt_q   <= '0;
            tmo_cnt_q      <= '0;
            match_q        <= '0;
            frame_nib_q    <= '0;
            frame_blank_q  <= '0;
            frame_inv_q    <= '0;
            seen_q         <= '0;
            prev_nib_q     <= '0;
            prev_blank_q   <= '0;
            value_q        <= '1;
            blank_q        <= '1;
            value_valid_q  <= 1'b0;
            pattern_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            mostrador_s1_q <= bus.mostrador;
            mostrador_s2_q <= mostrador_s1_q;
            digits_s1_q    <= bus.digits;
            digits_s2_q    <= digits_s1_q;
            sel_act_q      <= sel_act_d;
            settle_cnt_q   <= settle_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            match_q        <= match_d;
            frame_nib_q    <= frame_nib_d;
            frame_blank_q  <= frame_blank_d;
            frame_inv_q    <= frame_inv_d;
            seen_q         <= seen_d;
            prev_nib_q     <= prev_nib_d;
            prev_blank_q   <= prev_blank_d;
            value_q        <= value_d;
            blank_q        <= blank_d;
            value_valid_q  <= value_valid_d;
            pattern_err_q  <= pattern_err_d;
        end
    end

    assign bus.value       = value_q;
    assign bus.blank       = blank_q;
    assign bus.value_valid = value_valid_q;
    assign bus.pattern_err = pattern_err_q;
    assign bus.scan_lost   = (tmo_cnt_q == TW'(TIMEOUT_CYCLES));
endmodule

// File: tb/tb_seg_display_capture.sv
// Directed bench for seg_display_capture: scans BCD frames onto the active-low display bus.
module tb_seg_display_capture;
    logic clk_50mhz = 1'b0;
    logic init_pulse = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   vv_cnt = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    seg_display_capture_if bus ();

    seg_display_capture #(
        .SETTLE_CYCLES (64),
        .STABLE_FRAMES (3),
        .TIMEOUT_CYCLES(3000),
        .SEG_ACTIVE_LOW(1'b1),
        .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .init_pulse(init_pulse),
        .bus       (bus)
    );

    always @(posedge clk_50mhz) if (bus.value_valid === 1'b1) vv_cnt++;

    localparam logic [6:0] BAD_PAT = 7'b1000001;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            4'hF: return 7'b0000000;
            default: return BAD_PAT;
        endcase
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic go_idle();
        bus.digits    = 4'hF;
        bus.mostrador = 7'h7F;
    endtask

    task automatic show(input int idx, input logic [6:0] pat, input int dwell);
        logic [3:0] one;
        one = 4'b0001 << idx;
        bus.digits    = ~one;
        bus.mostrador = ~pat;
        wait_cyc(dwell);
    endtask

    task automatic scan_frame(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) show(i, seg_of(v[i*4 +: 4]), 200);
    endtask

    task automatic test_reset();
        go_idle();
        init_pulse = 1'b1;
        wait_cyc(2);
        init_pulse = 1'b0;
        wait_cyc(1);
        checks++; if (bus.value !== 16'hFFFF) begin errors++; $display("FAIL reset_value got %h exp %h", bus.value, 16'hFFFF); end
        checks++; if (bus.blank !== 4'hF) begin errors++; $display("FAIL reset_blank got %b exp %b", bus.blank, 4'hF); end
        checks++; if (bus.value_valid !== 1'b0) begin errors++; $display("FAIL reset_vv got %b exp 0", bus.value_valid); end
        checks++; if (bus.pattern_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", bus.pattern_err); end
        checks++; if (bus.scan_lost !== 1'b0) begin errors++; $display("FAIL reset_lost got %b exp 0", bus.scan_lost); end
    endtask

    task automatic test_clean_scan();
        int base;
        base = vv_cnt;
        scan_frame(16'h0427);
        scan_frame(16'h0427);
        checks++; if (vv_cnt !== base) begin errors++; $display("FAIL clean_no_early_pub got %0d exp %0d", vv_cnt, base); end
        checks++; if (bus.value !== 16'hFFFF) begin errors++; $display("FAIL clean_value_early got %h exp %h", bus.value, 16'hFFFF); end
        scan_frame(16'h0427);
        checks++; if (vv_cnt !== base + 1) begin errors++; $display("FAIL clean_pub_count got %0d exp %0d", vv_cnt, base + 1); end
        checks++; if (bus.value !== 16'h0427) begin errors++; $display("FAIL clean_value got %h exp %h", bus.value, 16'h0427); end
        checks++; if (bus.blank !== 4'b0000) begin errors++; $display("FAIL clean_blank got %b exp %b", bus.blank, 4'b0000); end
        scan_frame(16'h0427);
        checks++; if (vv_cnt !== base + 1) begin errors++; $display("FAIL clean_no_repulse got %0d exp %0d", vv_cnt, base + 1); end
    endtask

    task automatic test_blank_digit();
        int base;
        base = vv_cnt;
        repeat (3) scan_frame(16'hF059);
        checks++; if (bus.value !== 16'hF059) begin errors++; $display("FAIL blank_value got %h exp %h", bus.value, 16'hF059); end
        checks++; if (bus.blank !== 4'b1000) begin errors++; $display("FAIL blank_mask got %b exp %b", bus.blank, 4'b1000); end
        checks++; if (vv_cnt !== base + 1) begin errors++; $display("FAIL blank_pub_count got %0d exp %0d", vv_cnt, base + 1); end
    endtask

    task automatic test_invalid_pattern();
        int base;
        base = vv_cnt;
        scan_frame(16'h1234);
        show(3, seg_of(4'd1), 200);
        show(2, seg_of(4'd2), 200);
        show(1, BAD_PAT, 200);
        show(0, seg_of(4'd4), 200);
        checks++; if (bus.pattern_err !== 1'b1) begin errors++; $display("FAIL inv_perr_set got %b exp 1", bus.pattern_err); end
        checks++; if (bus.value !== 16'hF059) begin errors++; $display("FAIL inv_value_held got %h exp %h", bus.value, 16'hF059); end
        checks++; if (vv_cnt !== base) begin errors++; $display("FAIL inv_no_pub got %0d exp %0d", vv_cnt, base); end
        repeat (3) scan_frame(16'h1234);
        checks++; if (bus.pattern_err !== 1'b0) begin errors++; $display("FAIL inv_perr_clear got %b exp 0", bus.pattern_err); end
        checks++; if (bus.value !== 16'h1234) begin errors++; $display("FAIL inv_value_pub got %h exp %h", bus.value, 16'h1234); end
        checks++; if (vv_cnt !== base + 1) begin errors++; $display("FAIL inv_pub_count got %0d exp %0d", vv_cnt, base + 1); end
    endtask

    task automatic test_glitch();
        int base;
        base = vv_cnt;
        bus.digits    = 4'b1001;
        bus.mostrador = ~BAD_PAT;
        wait_cyc(10);
        show(3, BAD_PAT, 20);
        show(2, seg_of(4'd2), 200);
        show(1, seg_of(4'd3), 200);
        show(0, seg_of(4'd4), 200);
        // a sampled glitch on digit3 would have completed an invalid frame here
        checks++; if (bus.pattern_err !== 1'b0) begin errors++; $display("FAIL glitch_no_sample got %b exp 0", bus.pattern_err); end
        checks++; if (bus.value !== 16'h1234) begin errors++; $display("FAIL glitch_value got %h exp %h", bus.value, 16'h1234); end
        show(3, seg_of(4'd1), 200);
        checks++; if (bus.pattern_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_ok got %b exp 0", bus.pattern_err); end
        checks++; if (vv_cnt !== base) begin errors++; $display("FAIL glitch_no_pub got %0d exp %0d", vv_cnt, base); end
    endtask

    task automatic test_timeout();
        int base;
        int n;
        base = vv_cnt;
        checks++; if (bus.scan_lost !== 1'b0) begin errors++; $display("FAIL tmo_lost_before got %b exp 0", bus.scan_lost); end
        go_idle();
        n = 0;
        while (bus.scan_lost !== 1'b1 && n < 4000) begin
            @(negedge clk_50mhz);
            n++;
        end
        checks++; if (bus.scan_lost !== 1'b1) begin errors++; $display("FAIL tmo_lost_set got %b exp 1 after %0d cycles", bus.scan_lost, n); end
        checks++; if (bus.value !== 16'h1234) begin errors++; $display("FAIL tmo_value_held got %h exp %h", bus.value, 16'h1234); end
        show(3, seg_of(4'd1), 30);
        checks++; if (bus.scan_lost !== 1'b1) begin errors++; $display("FAIL tmo_lost_until_sample got %b exp 1", bus.scan_lost); end
        wait_cyc(170);
        checks++; if (bus.scan_lost !== 1'b0) begin errors++; $display("FAIL tmo_lost_clear got %b exp 0", bus.scan_lost); end
        show(2, seg_of(4'd2), 200);
        show(1, seg_of(4'd3), 200);
        show(0, seg_of(4'd4), 200);
        repeat (3) scan_frame(16'h1234);
        checks++; if (vv_cnt !== base) begin errors++; $display("FAIL tmo_no_repulse got %0d exp %0d", vv_cnt, base); end
    endtask

    task automatic test_init_mid_frame();
        int base;
        show(3, seg_of(4'd0), 200);
        show(2, seg_of(4'd4), 200);
        show(1, BAD_PAT, 200);
        go_idle();
        init_pulse = 1'b1;
        wait_cyc(1);
        init_pulse = 1'b0;
        base = vv_cnt;
        checks++; if (bus.value !== 16'hFFFF) begin errors++; $display("FAIL init_value got %h exp %h", bus.value, 16'hFFFF); end
        checks++; if (bus.blank !== 4'hF) begin errors++; $display("FAIL init_blank got %b exp %b", bus.blank, 4'hF); end
        checks++; if ({bus.value_valid, bus.pattern_err, bus.scan_lost} !== 3'b000) begin
            errors++; $display("FAIL init_flags got %b exp %b", {bus.value_valid, bus.pattern_err, bus.scan_lost}, 3'b000);
        end
        show(0, seg_of(4'd7), 200);
        // leftover slots from before the reset would complete an invalid frame here
        checks++; if (bus.pattern_err !== 1'b0) begin errors++; $display("FAIL init_partial_discard got %b exp 0", bus.pattern_err); end
        repeat (3) scan_frame(16'h0427);
        checks++; if (bus.value !== 16'h0427) begin errors++; $display("FAIL init_repub_value got %h exp %h", bus.value, 16'h0427); end
        checks++; if (vv_cnt !== base + 1) begin errors++; $display("FAIL init_repub_count got %0d exp %0d", vv_cnt, base + 1); end
    endtask

    initial begin
        go_idle();
        @(negedge clk_50mhz);
        test_reset();
        test_clean_scan();
        test_blank_digit();
        test_invalid_pattern();
        test_glitch();
        test_timeout();
        test_init_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
